// File: rtl/wts_envelope_scheduler.sv
// rtl/wts_envelope_scheduler.sv - time-multiplexed envelope context scheduler for CH_NUM channels
module wts_envelope_scheduler #(
   parameter int CH_NUM  = 6,
   parameter int CH_BITS = 3
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  sweep_start,
   input  logic [CH_NUM-1:0]     key_on_req,
   input  logic [CH_NUM-1:0]     key_release_req,
   input  logic [CH_NUM-1:0]     key_off_req,
   output logic                  busy,
   output logic                  sweep_done,
   output logic [CH_BITS-1:0]    eg_ch,
   output logic                  eg_key_on,
   output logic                  eg_key_release,
   output logic                  eg_key_off,
   output logic [15:0]           eg_counter_in,
   output logic [2:0]            eg_state_in,
   output logic [6:0]            eg_level_in,
   input  logic [15:0]           eg_counter_out,
   input  logic [2:0]            eg_state_out,
   input  logic [6:0]            eg_level_out,
   output logic [7*CH_NUM-1:0]   level_all,
   output logic [CH_NUM-1:0]     ch_active
);

   typedef enum logic {S_IDLE, S_SWEEP} fsm_t;

   fsm_t               fsm;
   logic [15:0]        counter [CH_NUM];
   logic [2:0]         state   [CH_NUM];
   logic [6:0]         level   [CH_NUM];
   logic [CH_NUM-1:0]  pon;
   logic [CH_NUM-1:0]  prel;
   logic [CH_NUM-1:0]  poff;
   logic               sel_on;
   logic               sel_rel;
   logic               sel_off;
   logic               last_ch;

   assign busy    = (fsm == S_SWEEP);
   assign last_ch = (eg_ch == CH_BITS'(CH_NUM - 1));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         fsm        <= S_IDLE;
         eg_ch      <= '0;
         sweep_done <= 1'b0;
         for (int n = 0; n < CH_NUM; n++) begin
            counter[n] <= '0;
            state[n]   <= '0;
            level[n]   <= '0;
         end
      end else begin
         sweep_done <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (sweep_start) begin
                  fsm   <= S_SWEEP;
                  eg_ch <= '0;
               end
            end
            S_SWEEP: begin
               for (int n = 0; n < CH_NUM; n++) begin
                  if (eg_ch == CH_BITS'(n)) begin
                     counter[n] <= eg_counter_out;
                     state[n]   <= eg_state_out;
                     level[n]   <= eg_level_out;
                  end
               end
               if (last_ch) begin
                  fsm        <= S_IDLE;
                  eg_ch      <= '0;
                  sweep_done <= 1'b1;
               end else begin
                  eg_ch <= eg_ch + CH_BITS'(1);
               end
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

   // A request landing on its own service cycle survives: the set below overrides the clear.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pon  <= '0;
         prel <= '0;
         poff <= '0;
      end else begin
         for (int n = 0; n < CH_NUM; n++) begin
            if (busy && (eg_ch == CH_BITS'(n))) begin
               pon[n]  <= 1'b0;
               prel[n] <= 1'b0;
               poff[n] <= 1'b0;
            end
            if (key_off_req[n]) begin
               poff[n] <= 1'b1;
               pon[n]  <= 1'b0;
               prel[n] <= 1'b0;
            end else if (key_on_req[n]) begin
               pon[n]  <= 1'b1;
               prel[n] <= 1'b0;
               poff[n] <= 1'b0;
            end else if (key_release_req[n]) begin
               prel[n] <= 1'b1;
               pon[n]  <= 1'b0;
               poff[n] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      eg_counter_in = '0;
      eg_state_in   = '0;
      eg_level_in   = '0;
      sel_on        = 1'b0;
      sel_rel       = 1'b0;
      sel_off       = 1'b0;
      for (int n = 0; n < CH_NUM; n++) begin
         if (eg_ch == CH_BITS'(n)) begin
            eg_counter_in = counter[n];
            eg_state_in   = state[n];
            eg_level_in   = level[n];
            sel_on        = pon[n];
            sel_rel       = prel[n];
            sel_off       = poff[n];
         end
      end
   end

   assign eg_key_on      = busy & sel_on;
   assign eg_key_release = busy & sel_rel;
   assign eg_key_off     = busy & sel_off;

   always_comb begin
      level_all = '0;
      ch_active = '0;
      for (int n = 0; n < CH_NUM; n++) begin
         level_all[7*n +: 7] = level[n];
         ch_active[n]        = (state[n] != 3'd0);
      end
   end

endmodule

// File: tb/tb_wts_envelope_scheduler.sv
// tb/tb_wts_envelope_scheduler.sv - directed bench for wts_envelope_scheduler
module tb_wts_envelope_scheduler;

   localparam int CH = 6;
   localparam int CB = 3;

   logic            clk;
   logic            nreset;
   logic            sweep_start;
   logic [CH-1:0]   key_on_req;
   logic [CH-1:0]   key_release_req;
   logic [CH-1:0]   key_off_req;
   logic            busy;
   logic            sweep_done;
   logic [CB-1:0]   eg_ch;
   logic            eg_key_on;
   logic            eg_key_release;
   logic            eg_key_off;
   logic [15:0]     eg_counter_in;
   logic [2:0]      eg_state_in;
   logic [6:0]      eg_level_in;
   logic [15:0]     eg_counter_out;
   logic [2:0]      eg_state_out;
   logic [6:0]      eg_level_out;
   logic [7*CH-1:0] level_all;
   logic [CH-1:0]   ch_active;

   int n_checks;
   int n_fail;

   logic [CH-1:0]   on_mask;
   logic [CH-1:0]   rel_mask;
   logic [CH-1:0]   off_mask;
   logic [CH-1:0]   busy_mask;
   logic [CB-1:0]   obs_ch  [CH];
   logic [7*CH-1:0] obs_lvl [CH];
   logic [15:0]     obs_cnt [CH];
   logic            done_seen;
   logic            done_busy;
   int              inj_idx;
   int              inj_kind;
   int              inj_ch;

   wts_envelope_scheduler #(.CH_NUM(CH), .CH_BITS(CB)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .sweep_start     (sweep_start),
      .key_on_req      (key_on_req),
      .key_release_req (key_release_req),
      .key_off_req     (key_off_req),
      .busy            (busy),
      .sweep_done      (sweep_done),
      .eg_ch           (eg_ch),
      .eg_key_on       (eg_key_on),
      .eg_key_release  (eg_key_release),
      .eg_key_off      (eg_key_off),
      .eg_counter_in   (eg_counter_in),
      .eg_state_in     (eg_state_in),
      .eg_level_in     (eg_level_in),
      .eg_counter_out  (eg_counter_out),
      .eg_state_out    (eg_state_out),
      .eg_level_out    (eg_level_out),
      .level_all       (level_all),
      .ch_active       (ch_active)
   );

   // Generator model: key_off -> state 0, key_on -> 1, release -> 4, else hold.
   assign eg_counter_out = eg_counter_in + 16'd1;
   assign eg_level_out   = eg_level_in + 7'd1;
   assign eg_state_out   = eg_key_off ? 3'd0 : eg_key_on ? 3'd1 : eg_key_release ? 3'd4 : eg_state_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_sweep();
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      for (int i = 0; i < CH; i++) begin
         @(negedge clk);
         busy_mask[i] = busy;
         obs_ch[i]    = eg_ch;
         on_mask[i]   = eg_key_on;
         rel_mask[i]  = eg_key_release;
         off_mask[i]  = eg_key_off;
         obs_lvl[i]   = level_all;
         obs_cnt[i]   = eg_counter_in;
         if (i == inj_idx) begin
            if (inj_kind == 0) key_release_req[inj_ch] = 1'b1;
            else               sweep_start = 1'b1;
         end
         @(posedge clk); #1;
         key_release_req = '0;
         sweep_start     = 1'b0;
      end
      @(negedge clk);
      done_seen = sweep_done;
      done_busy = busy;
      inj_idx   = -1;
   endtask

   task automatic test_reset();
      logic idle_ok;
      nreset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         sweep_start     = 1'($urandom);
         key_on_req      = CH'($urandom);
         key_release_req = CH'($urandom);
         key_off_req     = CH'($urandom);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", sweep_done); end
      n_checks++;
      if (level_all !== '0) begin n_fail++; $display("FAIL reset_level_all: got %h want 0", level_all); end
      n_checks++;
      if (ch_active !== '0) begin n_fail++; $display("FAIL reset_ch_active: got %b want 0", ch_active); end
      n_checks++;
      if ({eg_key_on, eg_key_release, eg_key_off} !== 3'b000) begin
         n_fail++; $display("FAIL reset_keys: got %b want 000", {eg_key_on, eg_key_release, eg_key_off});
      end
      n_checks++;
      if ({eg_ch, eg_counter_in, eg_state_in, eg_level_in} !== '0) begin
         n_fail++; $display("FAIL reset_gen_drive: got %h want 0", {eg_ch, eg_counter_in, eg_state_in, eg_level_in});
      end
      @(posedge clk); #1;
      sweep_start = 1'b0; key_on_req = '0; key_release_req = '0; key_off_req = '0;
      nreset = 1'b1;
      idle_ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || sweep_done !== 1'b0 || eg_key_on !== 1'b0) idle_ok = 1'b0;
      end
      n_checks++;
      if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL reset_idle_after: got %b want 1", idle_ok); end
   endtask

   task automatic test_basic_sweep();
      logic ch_ok;
      @(posedge clk); #1;
      do_sweep();
      ch_ok = 1'b1;
      for (int i = 0; i < CH; i++) if (obs_ch[i] !== CB'(i)) ch_ok = 1'b0;
      n_checks++;
      if (ch_ok !== 1'b1) begin n_fail++; $display("FAIL basic_ch_seq: got %0d,%0d,%0d,%0d,%0d,%0d want 0..5", obs_ch[0], obs_ch[1], obs_ch[2], obs_ch[3], obs_ch[4], obs_ch[5]); end
      n_checks++;
      if (busy_mask !== 6'b111111) begin n_fail++; $display("FAIL basic_busy: got %b want 111111", busy_mask); end
      n_checks++;
      if ({on_mask, rel_mask, off_mask} !== '0) begin n_fail++; $display("FAIL basic_keys: got %h want 0", {on_mask, rel_mask, off_mask}); end
      n_checks++;
      if ({done_seen, done_busy} !== 2'b10) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", done_seen, done_busy); end
      n_checks++;
      if (obs_lvl[0] !== '0) begin n_fail++; $display("FAIL basic_lvl_c1: got %h want 0", obs_lvl[0]); end
      n_checks++;
      if (obs_lvl[3] !== {7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1}) begin n_fail++; $display("FAIL basic_lvl_c4: got %h want %h", obs_lvl[3], {7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1}); end
      n_checks++;
      if (level_all !== {6{7'd1}}) begin n_fail++; $display("FAIL basic_level_all: got %h want %h", level_all, {6{7'd1}}); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", sweep_done); end
   endtask

   task automatic test_key_on();
      @(posedge clk); #1;
      key_on_req[2] = 1'b1;
      @(posedge clk); #1;
      key_on_req = '0;
      do_sweep();
      n_checks++;
      if (on_mask !== 6'b000100) begin n_fail++; $display("FAIL keyon_first: got %b want 000100", on_mask); end
      n_checks++;
      if (obs_cnt[4] !== 16'd1) begin n_fail++; $display("FAIL keyon_counter_in: got %0d want 1", obs_cnt[4]); end
      n_checks++;
      if (ch_active !== 6'b000100) begin n_fail++; $display("FAIL keyon_active: got %b want 000100", ch_active); end
      @(posedge clk); #1;
      do_sweep();
      n_checks++;
      if (on_mask !== 6'b000000) begin n_fail++; $display("FAIL keyon_second: got %b want 000000", on_mask); end
      n_checks++;
      if (level_all !== {6{7'd3}}) begin n_fail++; $display("FAIL keyon_level_all: got %h want %h", level_all, {6{7'd3}}); end
   endtask

   task automatic test_simultaneous();
      @(posedge clk); #1;
      key_on_req[1]  = 1'b1;
      key_off_req[1] = 1'b1;
      @(posedge clk); #1;
      key_on_req = '0; key_off_req = '0;
      do_sweep();
      n_checks++;
      if ({on_mask, rel_mask, off_mask} !== {6'b000000, 6'b000000, 6'b000010}) begin
         n_fail++; $display("FAIL simul_priority: got on=%b rel=%b off=%b want on=000000 rel=000000 off=000010", on_mask, rel_mask, off_mask);
      end
   endtask

   task automatic test_release_in_service();
      @(posedge clk); #1;
      inj_idx = 3; inj_kind = 0; inj_ch = 3;
      do_sweep();
      n_checks++;
      if (rel_mask !== 6'b000000) begin n_fail++; $display("FAIL rel_same_sweep: got %b want 000000", rel_mask); end
      @(posedge clk); #1;
      do_sweep();
      n_checks++;
      if (rel_mask !== 6'b001000) begin n_fail++; $display("FAIL rel_next_sweep: got %b want 001000", rel_mask); end
      n_checks++;
      if (ch_active !== 6'b001100) begin n_fail++; $display("FAIL rel_active: got %b want 001100", ch_active); end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      do_sweep();
      do_sweep();
      n_checks++;
      if (busy_mask !== 6'b111111 || obs_ch[0] !== 3'd0 || obs_ch[5] !== 3'd5) begin
         n_fail++; $display("FAIL b2b_second_sweep: got busy=%b ch0=%0d ch5=%0d want busy=111111 ch0=0 ch5=5", busy_mask, obs_ch[0], obs_ch[5]);
      end
      n_checks++;
      if (done_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done_seen); end
   endtask

   task automatic test_ignore_busy();
      @(posedge clk); #1;
      inj_idx = CH - 1; inj_kind = 1;
      do_sweep();
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_queued: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_midsweep();
      logic quiet_ok;
      @(posedge clk); #1;
      key_on_req[5] = 1'b1;
      @(posedge clk); #1;
      key_on_req  = '0;
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (eg_ch !== 3'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got ch=%0d busy=%b want ch=4 busy=1", eg_ch, busy); end
      nreset = 1'b0;
      #1;
      n_checks++;
      if ({busy, sweep_done, eg_ch} !== '0) begin n_fail++; $display("FAIL midrst_async: got busy=%b done=%b ch=%0d want 0", busy, sweep_done, eg_ch); end
      n_checks++;
      if (level_all !== '0 || ch_active !== '0) begin n_fail++; $display("FAIL midrst_storage: got lvl=%h act=%b want 0", level_all, ch_active); end
      @(posedge clk); #1;
      nreset = 1'b1;
      quiet_ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (sweep_done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
      end
      n_checks++;
      if (quiet_ok !== 1'b1) begin n_fail++; $display("FAIL midrst_no_done: got %b want 1", quiet_ok); end
      @(posedge clk); #1;
      do_sweep();
      n_checks++;
      if ({on_mask, rel_mask, off_mask} !== '0) begin n_fail++; $display("FAIL midrst_flags_lost: got on=%b rel=%b off=%b want 0", on_mask, rel_mask, off_mask); end
      n_checks++;
      if (level_all !== {6{7'd1}}) begin n_fail++; $display("FAIL midrst_level_all: got %h want %h", level_all, {6{7'd1}}); end
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      inj_idx         = -1;
      inj_kind        = 0;
      inj_ch          = 0;
      nreset          = 1'b0;
      sweep_start     = 1'b0;
      key_on_req      = '0;
      key_release_req = '0;
      key_off_req     = '0;
      test_reset();
      test_basic_sweep();
      test_key_on();
      test_simultaneous();
      test_release_in_service();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midsweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wts_envelope_scheduler.md
# wts_envelope_scheduler

Time-multiplexing controller that shares one combinational ADSR envelope generator among CH_NUM sound channels. It holds each channel's envelope context (counter, state, level) and latches key-on/release/off requests from the register interface. On each sweep it presents one channel per clock to the generator and writes the results back. The mixer reads the per-channel levels directly from this block.

## Interface
- CH_NUM, 6: number of channels, 2..16
- CH_BITS, 3: channel index width, ≥ clog2(CH_NUM)
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- sweep_start  in  1  pulse: begin one envelope sweep over all channels
- key_on_req  in  CH_NUM  per-channel pulse: request key-on
- key_release_req  in  CH_NUM  per-channel pulse: request release
- key_off_req  in  CH_NUM  per-channel pulse: request forced off
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after the last channel is written back
- eg_ch  out  CH_BITS  channel being serviced; selects that channel's AR/DR/SR/RR/SL externally
- eg_key_on, eg_key_release, eg_key_off  out  1 each  request pulses to the generator for eg_ch
- eg_counter_in  out  16  stored counter of eg_ch
- eg_state_in  out  3  stored state of eg_ch
- eg_level_in  out  7  stored level of eg_ch
- eg_counter_out  in  16  generator result
- eg_state_out  in  3  generator result
- eg_level_out  in  7  generator result
- level_all  out  7*CH_NUM  stored level of every channel; channel n is at bits [7n+6:7n]
- ch_active  out  CH_NUM  bit n = (stored state of channel n ≠ 0)

## Operation
- Storage: counter[CH_NUM], state[CH_NUM] and level[CH_NUM] registers, plus pending flags pon/prel/poff[CH_NUM]. All are 0 on reset.
- FSM has two states:
  - IDLE → SWEEP when sweep_start=1. eg_ch is set to 0.
  - SWEEP: each clock writes back eg_ch and increments eg_ch.
  - After eg_ch = CH_NUM-1 is written back: → IDLE, eg_ch is set to 0, and sweep_done=1 for one cycle.
- sweep_start while busy=1 is ignored and is not queued.
- Generator drive is combinational from storage indexed by eg_ch:
  - eg_counter_in = counter[eg_ch], eg_state_in = state[eg_ch], eg_level_in = level[eg_ch].
  - eg_key_on = busy & pon[eg_ch]; likewise eg_key_release (prel) and eg_key_off (poff).
  - In IDLE all eg_key_* are 0.
- Write-back on each SWEEP clock edge: counter[eg_ch], state[eg_ch] and level[eg_ch] take eg_counter_out, eg_state_out and eg_level_out.
- Pending flag update per channel n, evaluated every clock:
  - Step 1, clear on service: if channel n is serviced this cycle, its presented flags clear.
  - Step 2, new request: a new request sets its own flag and clears the other two flags of that channel (last request wins).
  - Simultaneous requests in one cycle on one channel: key_off > key_on > key_release. Only the winner is set.
  - A request arriving in the same cycle its channel is serviced is not presented in that cycle. It remains pending for the next sweep; step 2 overrides step 1.
- At most one of pon/prel/poff is set per channel at any time.
- level_all and ch_active are driven directly from storage. They change only at write-back edges or at reset.

## Timing
- Reset values: busy=0, sweep_done=0, eg_ch=0, eg_key_*=0, level_all=0, ch_active=0. eg_counter_in, eg_state_in and eg_level_in read 0.
- Cycle 0: sweep_start is sampled high.
- Cycles 1..CH_NUM: busy=1 and eg_ch = 0..CH_NUM-1.
- Cycle CH_NUM+1: busy=0 and sweep_done=1.
- One sweep therefore takes CH_NUM clocks. Throughput is one sweep per CH_NUM+1 clocks: sweep_start in the sweep_done cycle is accepted.
- Write-back latency is 1 clock. Channel n's new level is visible on level_all in cycle n+2, counting from the cycle in which sweep_start is sampled.
- A request pulse arriving in cycle t reaches its channel in the first service cycle strictly after t.
- nreset asserted mid-sweep: all state clears immediately (asynchronously), busy=0, no sweep_done pulse, and all pending flags are lost.

## Test plan
- Reset: hold nreset=0 with random inputs → busy=0, level_all=0, ch_active=0, eg_key_*=0. After release, no activity until sweep_start.
- Basic sweep with CH_NUM=6: sweep_start at cycle 0 → eg_ch 0,1,2,3,4,5 in cycles 1..6, sweep_done in cycle 7. A generator model returning level_in+1 gives level_all channels = 1 each.
- key_on_req[2] while IDLE, then two sweeps → eg_key_on=1 only while eg_ch=2 of the first sweep. Second sweep has eg_key_on=0 throughout. ch_active[2]=1 once the generator returns state 1.
- key_on_req[1] and key_off_req[1] in the same cycle → next sweep presents eg_key_off=1 and eg_key_on=0 at eg_ch=1.
- key_release_req[3] pulsed in the cycle eg_ch=3 is serviced → eg_key_release=0 in that sweep, 1 at eg_ch=3 of the next sweep.
- nreset pulsed at eg_ch=4 with key_on_req[5] pending → busy=0, no sweep_done, storage cleared. The following sweep presents no key events.
